adc_sample_sched: RTL and testbench
===================================

Name: adc_sample_sched

Overview:
- Scheduler for the single shared multi-channel ADC driver in the FOC current-sense path.
- On each one-cycle sample trigger from the PWM-low hold detector, it sequences three phase conversions A, B, C back-to-back and publishes them together.
- Between triggers, it shares idle ADC time with one low-priority auxiliary requester (bus voltage, temperature).
- Trigger always has priority; conversions in flight are never aborted except on timeout.

Parameters:
- CH_A, 3'd0, ADC channel for phase A current.
- CH_B, 3'd1, ADC channel for phase B current.
- CH_C, 3'd2, ADC channel for phase C current.
- TIMEOUT, 16'd2000, max clk cycles from conv_start to conv_done before abort; must be nonzero.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- trig  in  1  one-cycle sample request pulse.
- aux_req  in  1  level auxiliary conversion request.
- aux_ch  in  3  auxiliary channel, sampled on acceptance.
- aux_valid  out  1  one-cycle pulse: aux conversion finished (acknowledge).
- aux_err  out  1  qualifies aux_valid: 1 = timed out, aux_data not updated.
- aux_data  out  12  last good aux result.
- conv_start  out  1  one-cycle conversion start pulse to ADC driver.
- conv_ch  out  3  channel, held stable from conv_start until conv_done or timeout.
- conv_done  in  1  one-cycle pulse from driver; conv_data valid same cycle.
- conv_data  in  12  conversion result.
- ia, ib, ic  out  12 each  phase results, updated atomically.
- ph_valid  out  1  one-cycle pulse, phase registers just updated.
- overrun  out  1  one-cycle pulse, trig dropped.
- tmo  out  1  one-cycle pulse, conversion timed out.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, conv_ch = 0, state IDLE, pending flag cleared, timer cleared. Applies mid-conversion too; a late conv_done after reset is ignored.
- States:
  - IDLE
  - PH_START(k), PH_WAIT(k), k = A, B, C
  - AUX_START, AUX_WAIT
- IDLE transitions:
  - trig = 1 or pending = 1 -> PH_START(A); clears pending. Trig wins over a simultaneous aux_req.
  - Otherwise, aux_req = 1 -> AUX_START; latches aux_ch.
- START states:
  - Drive conv_start = 1 for one cycle with the proper conv_ch.
  - Load timer = TIMEOUT.
  - Go to the matching WAIT state.
- WAIT states:
  - Timer decrements each cycle.
  - conv_done -> capture conv_data into a shadow register.
  - In PH_WAIT, after A go to PH_START(B), after B go to PH_START(C). After C, go to IDLE and, on the next edge, load ia/ib/ic from the shadows simultaneously with ph_valid = 1.
  - In AUX_WAIT, conv_done -> aux_data <= conv_data, aux_valid = 1, aux_err = 0, go to IDLE.
- Latency:
  - trig in IDLE at edge T -> conv_start high in cycle T+1.
  - ph_valid one cycle after conv_done of C.
- Timeout: timer reaches 0 in a WAIT state without conv_done -> tmo = 1, go to IDLE.
  - Phase sequence: abandoned; ia/ib/ic unchanged; ph_valid not asserted.
  - Aux: aux_valid = 1 and aux_err = 1.
  - conv_done and timer expiry in the same cycle: treated as done.
- trig during AUX_START/AUX_WAIT: sets pending; the phase sequence starts immediately after aux completes.
- trig while pending already set, or during any PH state: dropped, overrun = 1.
- conv_done in IDLE/START states: ignored.
- aux_req still high after aux_valid: treated as a new request.

Optional Feature:
- Macro: ADC_SCHED_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt[15:0], reset 0.
  - Increments on every overrun pulse and every phase-sequence timeout.
  - Saturates at 16'hFFFF.
  - Cleared by one-cycle input cnt_clr; cnt_clr wins over a simultaneous increment.
- Undefined: neither port exists, no counter logic; all other behaviour identical.

Decomposition:
- Package adc_sched_pkg:
  - State encoding localparams.
  - Data width 12 and channel width 3 constants.
- One sub-module, adc_conv_timer: load/decrement/expire countdown with inputs load and run, output expired. Used by the scheduler for both phase and aux waits.

Test Plan:
- Phase sequence: trig in IDLE, driver answers 0x111/0x222/0x333 after 50 cycles each -> conv_ch 0, 1, 2 in order; ia = 0x111, ib = 0x222, ic = 0x333; ph_valid single pulse; conv_start at T+1.
- Simultaneous trig and aux_req (aux_ch = 5) -> phase sequence first, then AUX on ch 5; aux_valid with aux_err = 0 and aux_data = driver value.
- Trig during AUX_WAIT, then a second trig still during AUX_WAIT -> pending set by the first; second gives overrun = 1; phase sequence starts the cycle after aux completes.
- TIMEOUT = 100, driver silent on channel B -> tmo after 100 cycles; no ph_valid; ia/ib/ic hold previous values; busy = 0.
- rstn pulsed low during PH_WAIT(B), stray conv_done after release -> all outputs 0, state IDLE, no ph_valid.
- With ADC_SCHED_OVERRUN_CNT_EN: 3 overruns plus 1 phase timeout -> overrun_cnt = 4; cnt_clr -> 0.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared constants, state encoding and helpers for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int DATA_W = 12;
    localparam int CH_W   = 3;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PH_START_A = 3'd1;
    localparam logic [2:0] S_PH_WAIT_A  = 3'd2;
    localparam logic [2:0] S_PH_START_B = 3'd3;
    localparam logic [2:0] S_PH_WAIT_B  = 3'd4;
    localparam logic [2:0] S_PH_START_C = 3'd5;
    localparam logic [2:0] S_PH_WAIT_C  = 3'd6;
    localparam logic [2:0] S_AUX        = 3'd7;

    typedef enum logic [3:0] {
        IDLE       = {1'b0, S_IDLE},
        PH_START_A = {1'b0, S_PH_START_A},
        PH_WAIT_A  = {1'b0, S_PH_WAIT_A},
        PH_START_B = {1'b0, S_PH_START_B},
        PH_WAIT_B  = {1'b0, S_PH_WAIT_B},
        PH_START_C = {1'b0, S_PH_START_C},
        PH_WAIT_C  = {1'b0, S_PH_WAIT_C},
        AUX_START  = {1'b0, S_AUX},
        AUX_WAIT   = {1'b1, S_AUX}
    } state_t;

    // True for any state belonging to the three-phase sequence.
    function automatic logic is_ph_state(input state_t s);
        case (s)
            PH_START_A, PH_WAIT_A, PH_START_B,
            PH_WAIT_B, PH_START_C, PH_WAIT_C: is_ph_state = 1'b1;
            default:                          is_ph_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc_sample_sched_if.sv
// Handshake between the scheduler (master) and the shared ADC driver (slave).
interface adc_sample_sched_if;
    import adc_sched_pkg::*;

    logic              conv_start;
    logic [CH_W-1:0]   conv_ch;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;

    modport master (output conv_start, output conv_ch, input conv_done, input conv_data);
    modport slave  (input conv_start, input conv_ch, output conv_done, output conv_data);
endinterface

// File: rtl/adc_conv_timer.sv
// Conversion watchdog: loaded on conv_start, counts down while waiting.
// expired flags the wait cycle whose decrement brings the count to zero.
module adc_conv_timer #(
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic run,
    output logic expired
);
    logic [15:0] count_r;

    // Countdown register: load has priority, then decrement while running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= 16'd0;
        end else if (load) begin
            count_r <= TIMEOUT;
        end else if (run && (count_r != 16'd0)) begin
            count_r <= count_r - 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run && (count_r == 16'd1);
endmodule

// File: rtl/adc_sample_sched.sv
// Three-phase current-sense ADC scheduler with auxiliary idle-time sharing.
// Optional: define ADC_SCHED_OVERRUN_CNT_EN to add cnt_clr / overrun_cnt.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter logic [2:0]  CH_A    = 3'd0,
    parameter logic [2:0]  CH_B    = 3'd1,
    parameter logic [2:0]  CH_C    = 3'd2,
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    input  logic                 cnt_clr,
    output logic [15:0]          overrun_cnt,
`endif
    input  logic                 trig,
    input  logic                 aux_req,
    input  logic [CH_W-1:0]      aux_ch,
    output logic                 aux_valid,
    output logic                 aux_err,
    output logic [DATA_W-1:0]    aux_data,
    adc_sample_sched_if.master   adc,
    output logic [DATA_W-1:0]    ia,
    output logic [DATA_W-1:0]    ib,
    output logic [DATA_W-1:0]    ic,
    output logic                 ph_valid,
    output logic                 overrun,
    output logic                 tmo,
    output logic                 busy
);
    state_t            state_r, state_n;
    logic              pending_r, pending_n;
    logic [CH_W-1:0]   conv_ch_r, conv_ch_n, aux_ch_r, aux_ch_n;
    logic              conv_start_r, tmo_r, overrun_r, aux_valid_r, aux_err_r, ph_valid_r, busy_r;
    logic              tmo_n, overrun_n, aux_valid_n, aux_err_n;
    logic              load_s, run_s, expired_s;
    logic              cap_a_s, cap_b_s, commit_s, aux_cap_s, ph_tmo_s;
    logic [DATA_W-1:0] sh_a_r, sh_b_r, ia_r, ib_r, ic_r, aux_data_r;

    adc_conv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load_s),
        .run     (run_s),
        .expired (expired_s)
    );

    // Next-state, trigger arbitration and registered-output next values.
    always_comb begin
        state_n     = state_r;
        pending_n   = pending_r;
        aux_ch_n    = aux_ch_r;
        conv_ch_n   = conv_ch_r;
        tmo_n       = 1'b0;
        overrun_n   = 1'b0;
        aux_valid_n = 1'b0;
        aux_err_n   = 1'b0;
        load_s      = 1'b0;
        run_s       = 1'b0;
        cap_a_s     = 1'b0;
        cap_b_s     = 1'b0;
        commit_s    = 1'b0;
        aux_cap_s   = 1'b0;
        ph_tmo_s    = 1'b0;

        // A trigger outside IDLE is either parked (aux busy) or dropped.
        if (trig && is_ph_state(state_r)) begin
            overrun_n = 1'b1;
        end else if (trig && (state_r == AUX_START || state_r == AUX_WAIT)) begin
            if (pending_r) begin
                overrun_n = 1'b1;
            end else begin
                pending_n = 1'b1;
            end
        end else begin
            overrun_n = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (trig || pending_r) begin
                    state_n   = PH_START_A;
                    pending_n = 1'b0;
                end else if (aux_req) begin
                    state_n  = AUX_START;
                    aux_ch_n = aux_ch;
                end else begin
                    state_n = IDLE;
                end
            end
            PH_START_A: begin load_s = 1'b1; state_n = PH_WAIT_A; end
            PH_START_B: begin load_s = 1'b1; state_n = PH_WAIT_B; end
            PH_START_C: begin load_s = 1'b1; state_n = PH_WAIT_C; end
            AUX_START:  begin load_s = 1'b1; state_n = AUX_WAIT;  end
            PH_WAIT_A, PH_WAIT_B, PH_WAIT_C: begin
                run_s = 1'b1;
                if (adc.conv_done) begin
                    cap_a_s  = (state_r == PH_WAIT_A);
                    cap_b_s  = (state_r == PH_WAIT_B);
                    commit_s = (state_r == PH_WAIT_C);
                    if (state_r == PH_WAIT_A) begin
                        state_n = PH_START_B;
                    end else if (state_r == PH_WAIT_B) begin
                        state_n = PH_START_C;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (expired_s) begin
                    tmo_n    = 1'b1;
                    ph_tmo_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n = state_r;
                end
            end
            AUX_WAIT: begin
                run_s = 1'b1;
                if (adc.conv_done || expired_s) begin
                    aux_valid_n = 1'b1;
                    aux_err_n   = !adc.conv_done;
                    tmo_n       = !adc.conv_done;
                    aux_cap_s   = adc.conv_done;
                    // A parked trigger starts the phase sequence right away.
                    if (pending_n) begin
                        state_n   = PH_START_A;
                        pending_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    state_n = AUX_WAIT;
                end
            end
            default: state_n = IDLE;
        endcase

        // Channel is set on entry to a start state and held afterwards.
        case (state_n)
            PH_START_A: conv_ch_n = CH_A;
            PH_START_B: conv_ch_n = CH_B;
            PH_START_C: conv_ch_n = CH_C;
            AUX_START:  conv_ch_n = aux_ch_n;
            default:    conv_ch_n = conv_ch_r;
        endcase
    end

    // State, control and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            pending_r    <= 1'b0;
            aux_ch_r     <= 3'd0;
            conv_ch_r    <= 3'd0;
            conv_start_r <= 1'b0;
            tmo_r        <= 1'b0;
            overrun_r    <= 1'b0;
            aux_valid_r  <= 1'b0;
            aux_err_r    <= 1'b0;
            ph_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            sh_a_r       <= 12'd0;
            sh_b_r       <= 12'd0;
            ia_r         <= 12'd0;
            ib_r         <= 12'd0;
            ic_r         <= 12'd0;
            aux_data_r   <= 12'd0;
        end else begin
            state_r      <= state_n;
            pending_r    <= pending_n;
            aux_ch_r     <= aux_ch_n;
            conv_ch_r    <= conv_ch_n;
            conv_start_r <= (state_n == PH_START_A) || (state_n == PH_START_B) ||
                            (state_n == PH_START_C) || (state_n == AUX_START);
            tmo_r        <= tmo_n;
            overrun_r    <= overrun_n;
            aux_valid_r  <= aux_valid_n;
            aux_err_r    <= aux_err_n;
            ph_valid_r   <= commit_s;
            busy_r       <= (state_n != IDLE);
            sh_a_r       <= cap_a_s ? adc.conv_data : sh_a_r;
            sh_b_r       <= cap_b_s ? adc.conv_data : sh_b_r;
            aux_data_r   <= aux_cap_s ? adc.conv_data : aux_data_r;
            if (commit_s) begin
                ia_r <= sh_a_r;
                ib_r <= sh_b_r;
                ic_r <= adc.conv_data;
            end else begin
                ia_r <= ia_r;
                ib_r <= ib_r;
                ic_r <= ic_r;
            end
        end
    end

`ifdef ADC_SCHED_OVERRUN_CNT_EN
    logic [15:0] cnt_r;
    logic [16:0] cnt_sum_s;

    // Sum of this cycle's dropped trigger and phase timeout events.
    always_comb begin
        cnt_sum_s = {1'b0, cnt_r} + {16'd0, overrun_n} + {16'd0, ph_tmo_s};
    end

    // Saturating event counter; clear wins over increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= 16'd0;
        end else if (cnt_clr) begin
            cnt_r <= 16'd0;
        end else if (cnt_sum_s[16]) begin
            cnt_r <= 16'hFFFF;
        end else begin
            cnt_r <= cnt_sum_s[15:0];
        end
    end

    assign overrun_cnt = cnt_r;
`endif

    assign adc.conv_start = conv_start_r;
    assign adc.conv_ch    = conv_ch_r;
    assign aux_valid      = aux_valid_r;
    assign aux_err        = aux_err_r;
    assign aux_data       = aux_data_r;
    assign ia             = ia_r;
    assign ib             = ib_r;
    assign ic             = ic_r;
    assign ph_valid       = ph_valid_r;
    assign overrun        = overrun_r;
    assign tmo            = tmo_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_adc_sample_sched.sv
// Directed bench for adc_sample_sched, built with TIMEOUT = 100.
module tb_adc_sample_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trig = 1'b0;
    logic        aux_req = 1'b0;
    logic [2:0]  aux_ch = 3'd0;
    logic        aux_valid, aux_err, ph_valid, overrun, tmo, busy;
    logic [11:0] aux_data, ia, ib, ic;
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] overrun_cnt;
`endif
    int total = 0;
    int bad = 0;

    adc_sample_sched_if adc();

    adc_sample_sched #(.TIMEOUT(16'd100)) dut (
        .clk(clk), .rstn(rstn),
`ifdef ADC_SCHED_OVERRUN_CNT_EN
        .cnt_clr(cnt_clr), .overrun_cnt(overrun_cnt),
`endif
        .trig(trig), .aux_req(aux_req), .aux_ch(aux_ch),
        .aux_valid(aux_valid), .aux_err(aux_err), .aux_data(aux_data),
        .adc(adc.master), .ia(ia), .ib(ib), .ic(ic),
        .ph_valid(ph_valid), .overrun(overrun), .tmo(tmo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Driver model: stay silent dly cycles, then a one-cycle done with data.
    // Returns on the negedge one cycle after the done cycle.
    task automatic respond(input logic [11:0] d, input int dly);
        repeat (dly) @(negedge clk);
        adc.conv_done = 1'b1;
        adc.conv_data = d;
        @(negedge clk);
        adc.conv_done = 1'b0;
        adc.conv_data = 12'h000;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        total++; if ({ia, ib, ic, aux_data} !== 48'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {ia, ib, ic, aux_data}); end
        total++; if ({adc.conv_start, adc.conv_ch, ph_valid, aux_valid, aux_err, overrun, tmo, busy} !== 10'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {adc.conv_start, adc.conv_ch, ph_valid, aux_valid, aux_err, overrun, tmo, busy}); end
`ifdef ADC_SCHED_OVERRUN_CNT_EN
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", overrun_cnt); end
`endif
        rstn = 1'b1;
        tick();
    endtask

    // Trig at an edge, conv_start visible in the next cycle, then A/B/C.
    task automatic test_phase_seq();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        total++; if ({adc.conv_start, adc.conv_ch, busy} !== 5'b1_000_1) begin bad++; $display("FAIL seq_start_a got=%b exp=10001", {adc.conv_start, adc.conv_ch, busy}); end
        tick();
        respond(12'h111, 50);
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_001) begin bad++; $display("FAIL seq_start_b got=%b exp=1001", {adc.conv_start, adc.conv_ch}); end
        total++; if (ph_valid !== 1'b0) begin bad++; $display("FAIL seq_early_valid got=%b exp=0", ph_valid); end
        tick();
        respond(12'h222, 50);
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_010) begin bad++; $display("FAIL seq_start_c got=%b exp=1010", {adc.conv_start, adc.conv_ch}); end
        tick();
        respond(12'h333, 50);
        total++; if (ph_valid !== 1'b1) begin bad++; $display("FAIL seq_ph_valid got=%b exp=1", ph_valid); end
        total++; if ({ia, ib, ic} !== 36'h111_222_333) begin bad++; $display("FAIL seq_results got=%h exp=111222333", {ia, ib, ic}); end
        tick();
        total++; if ({ph_valid, busy} !== 2'b00) begin bad++; $display("FAIL seq_pulse_end got=%b exp=00", {ph_valid, busy}); end
    endtask

    // Simultaneous trig and aux_req: phases first, then aux on channel 5.
    task automatic test_trig_and_aux();
        trig = 1'b1; aux_req = 1'b1; aux_ch = 3'd5;
        tick();
        trig = 1'b0;
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_000) begin bad++; $display("FAIL ta_start_a got=%b exp=1000", {adc.conv_start, adc.conv_ch}); end
        tick(); respond(12'h0A1, 5); tick(); respond(12'h0B2, 5); tick(); respond(12'h0C3, 5);
        total++; if ({ph_valid, ia, ib, ic} !== {1'b1, 36'h0A1_0B2_0C3}) begin bad++; $display("FAIL ta_phases got=%h exp=10a10b20c3", {ph_valid, ia, ib, ic}); end
        tick();
        aux_req = 1'b0;
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_101) begin bad++; $display("FAIL ta_aux_start got=%b exp=1101", {adc.conv_start, adc.conv_ch}); end
        tick();
        respond(12'hABC, 20);
        total++; if ({aux_valid, aux_err, aux_data} !== {2'b10, 12'hABC}) begin bad++; $display("FAIL ta_aux_done got=%h exp=2abc", {aux_valid, aux_err, aux_data}); end
        tick();
        total++; if (aux_valid !== 1'b0) begin bad++; $display("FAIL ta_aux_pulse got=%b exp=0", aux_valid); end
    endtask

    // Two trigs during an aux wait: first parks, second overruns.
    task automatic test_pending();
        aux_req = 1'b1; aux_ch = 3'd3;
        tick();
        aux_req = 1'b0;
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_011) begin bad++; $display("FAIL pend_aux_start got=%b exp=1011", {adc.conv_start, adc.conv_ch}); end
        repeat (6) tick();
        trig = 1'b1; tick(); trig = 1'b0;
        total++; if ({overrun, adc.conv_start} !== 2'b00) begin bad++; $display("FAIL pend_first got=%b exp=00", {overrun, adc.conv_start}); end
        repeat (3) tick();
        trig = 1'b1; tick(); trig = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL pend_overrun got=%b exp=1", overrun); end
        tick();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL pend_overrun_pulse got=%b exp=0", overrun); end
        respond(12'h0A5, 10);
        total++; if ({aux_valid, aux_data, adc.conv_start, adc.conv_ch} !== {1'b1, 12'h0A5, 1'b1, 3'd0}) begin
            bad++; $display("FAIL pend_handover got=%h exp=%h", {aux_valid, aux_data, adc.conv_start, adc.conv_ch}, {1'b1, 12'h0A5, 1'b1, 3'd0}); end
        tick(); respond(12'h444, 3); tick(); respond(12'h555, 3); tick(); respond(12'h666, 3);
        total++; if ({ph_valid, ia, ib, ic} !== {1'b1, 36'h444_555_666}) begin bad++; $display("FAIL pend_phases got=%h exp=1444555666", {ph_valid, ia, ib, ic}); end
        tick();
    endtask

    // Silent on B: 100 wait cycles then tmo one cycle later (101 from conv_start).
    task automatic test_timeout();
        int n;
        logic saw_valid;
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        respond(12'h777, 10);
        total++; if ({adc.conv_start, adc.conv_ch} !== 4'b1_001) begin bad++; $display("FAIL tmo_start_b got=%b exp=1001", {adc.conv_start, adc.conv_ch}); end
        n = 0; saw_valid = 1'b0;
        while (tmo !== 1'b1 && n < 300) begin
            tick();
            n++;
            saw_valid = saw_valid | ph_valid;
        end
        total++; if (n !== 101) begin bad++; $display("FAIL tmo_latency got=%0d exp=101", n); end
        total++; if ({saw_valid, busy} !== 2'b00) begin bad++; $display("FAIL tmo_no_valid got=%b exp=00", {saw_valid, busy}); end
        total++; if ({ia, ib, ic} !== 36'h444_555_666) begin bad++; $display("FAIL tmo_hold got=%h exp=444555666", {ia, ib, ic}); end
        tick();
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%b exp=0", tmo); end
    endtask

    // Reset during PH_WAIT(B) followed by a stray done.
    task automatic test_reset_mid();
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        respond(12'h888, 5);
        repeat (10) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++; if ({busy, adc.conv_start, adc.conv_ch, ia, ib, ic} !== 41'd0) begin
            bad++; $display("FAIL rmid_cleared got=%h exp=0", {busy, adc.conv_start, adc.conv_ch, ia, ib, ic}); end
        adc.conv_done = 1'b1; adc.conv_data = 12'hFFF;
        tick();
        adc.conv_done = 1'b0; adc.conv_data = 12'h000;
        repeat (2) tick();
        total++; if ({ph_valid, aux_valid, busy, adc.conv_start, ia, ic} !== 28'd0) begin
            bad++; $display("FAIL rmid_stray got=%h exp=0", {ph_valid, aux_valid, busy, adc.conv_start, ia, ic}); end
    endtask

`ifdef ADC_SCHED_OVERRUN_CNT_EN
    // Three dropped trigs plus one phase timeout, then clear.
    task automatic test_overrun_cnt();
        int n;
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL cnt_start got=%0d exp=0", overrun_cnt); end
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1; tick(); trig = 1'b0; tick();
        end
        n = 0;
        while (tmo !== 1'b1 && n < 300) begin tick(); n++; end
        total++; if (overrun_cnt !== 16'd4) begin bad++; $display("FAIL cnt_four got=%0d exp=4", overrun_cnt); end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", overrun_cnt); end
    endtask
`endif

    initial begin
        adc.conv_done = 1'b0;
        adc.conv_data = 12'h000;
        tick();
        test_reset();
        test_phase_seq();
        test_trig_and_aux();
        test_pending();
        test_timeout();
        test_reset_mid();
`ifdef ADC_SCHED_OVERRUN_CNT_EN
        test_overrun_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
